// File: rtl/inv_pkg.sv
// inv_pkg: shared constants and types for the inv result collector.
package inv_pkg;
    localparam int W_DEFAULT = 8;
    localparam int CNT_W_DEFAULT = 16;
    typedef logic [W_DEFAULT-1:0] inv_word_t;
    typedef logic [$clog2(W_DEFAULT+1)-1:0] ones_t;
    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_e;
endpackage

// File: rtl/inv_out_slot.sv
// inv_out_slot: single-entry valid/ready output register with handshake count and sticky overflow.
module inv_out_slot
    import inv_pkg::*;
#(
    parameter int W = W_DEFAULT,
    parameter int OW = $clog2(W_DEFAULT+1),
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [W-1:0]     load_word,
    input  logic [OW-1:0]    load_ones,
    input  logic             word_ready,
    output logic [W-1:0]     word_out,
    output logic             word_valid,
    output logic [OW-1:0]    ones_out,
    output logic [CNT_W-1:0] word_cnt,
    output logic             overflow
);
    slot_state_e state;
    logic hs, accept, drop;
    assign word_valid = (state == SLOT_FULL);
    assign hs = word_valid && word_ready;
    // a slot that drains this cycle can take the new word with no bubble
    assign accept = load && (!word_valid || word_ready);
    assign drop = load && word_valid && !word_ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SLOT_EMPTY;
            word_out <= '0;
            ones_out <= '0;
            word_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                word_out <= load_word;
                ones_out <= load_ones;
            end
            state    <= accept ? SLOT_FULL : (hs ? SLOT_EMPTY : state);
            word_cnt <= word_cnt + CNT_W'(hs);
            overflow <= overflow | drop;
        end
    end
endmodule

// File: rtl/inv_out_collector.sv
// inv_out_collector: packs the inv Y1 bit stream LSB-first into words and offers them on valid/ready.
module inv_out_collector
    import inv_pkg::*;
#(
    parameter int W = W_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   y_in,
    input  logic                   y_valid,
    input  logic                   flush,
    output logic [W-1:0]           word_out,
    output logic                   word_valid,
    input  logic                   word_ready,
    output logic [$clog2(W+1)-1:0] ones_out,
    output logic [CNT_W-1:0]       word_cnt,
    output logic                   overflow
);
    localparam int BW = $clog2(W);
    localparam int OW = $clog2(W+1);
    logic [BW-1:0] bc;
    logic [W-1:0] asm_word, full_word;
    logic [OW-1:0] pop, full_ones;
    logic take, done;
    assign take = y_valid && !flush;
    assign done = take && (bc == BW'(W-1));
    // the last bit bypasses the assembly register so the word loads on its own edge
    assign full_word = asm_word | ({{(W-1){1'b0}}, y_in} << (W-1));
    assign full_ones = pop + OW'(y_in);
    always_ff @(posedge clk) begin
        if (rst || flush || done) begin
            bc       <= '0;
            asm_word <= '0;
            pop      <= '0;
        end else if (take) begin
            asm_word[bc] <= y_in;
            pop          <= full_ones;
            bc           <= bc + BW'(1);
        end
    end
    inv_out_slot #(.W(W), .OW(OW), .CNT_W(CNT_W)) slot (
        .clk(clk),
        .rst(rst),
        .load(done),
        .load_word(full_word),
        .load_ones(full_ones),
        .word_ready(word_ready),
        .word_out(word_out),
        .word_valid(word_valid),
        .ones_out(ones_out),
        .word_cnt(word_cnt),
        .overflow(overflow)
    );
endmodule

// File: tb/tb_inv_out_collector.sv
// tb_inv_out_collector: table-driven and scoreboard checks of the collector at CNT_W=16 and CNT_W=4.
module tb_inv_out_collector;
    logic clk = 1'b0;
    logic rst, y_in, y_valid, flush, word_ready;
    logic [7:0] word_out, word_out4;
    logic word_valid, word_valid4, overflow, overflow4;
    logic [3:0] ones_out, ones_out4, word_cnt4;
    logic [15:0] word_cnt;
    always #5 clk = ~clk;

    inv_out_collector #(.W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .y_in(y_in), .y_valid(y_valid), .flush(flush),
        .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
        .ones_out(ones_out), .word_cnt(word_cnt), .overflow(overflow)
    );
    inv_out_collector #(.W(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .y_in(y_in), .y_valid(y_valid), .flush(flush),
        .word_out(word_out4), .word_valid(word_valid4), .word_ready(word_ready),
        .ones_out(ones_out4), .word_cnt(word_cnt4), .overflow(overflow4)
    );

    typedef struct {
        logic [7:0] w;
        logic       sparse;
        logic [3:0] ones;
    } vec_t;
    vec_t tbl[8];
    logic [11:0] sb[$];
    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard: every handshake must match the oldest expected word
    always @(negedge clk) begin : monitor
        logic [11:0] e;
        if (!rst && word_valid && word_ready) begin
            exp_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %0h expected none", word_out);
            end else begin
                e = sb.pop_front();
                chk("hs_word", word_out, e[7:0]);
                chk("hs_ones", ones_out, e[11:8]);
                chk("hs_word4", word_out4, e[7:0]);
                chk("hs_ones4", ones_out4, e[11:8]);
            end
        end
    end

    task automatic drive(input logic v, input logic b, input logic f);
        y_valid = v;
        y_in = b;
        flush = f;
        @(posedge clk);
        #1;
        y_valid = 1'b0;
        flush = 1'b0;
        y_in = ~b;
    endtask

    task automatic send_word(input logic [7:0] w, input logic sparse, input logic push,
                             input logic [3:0] ones, input logic rdy_last);
        for (int i = 0; i < 8; i++) begin
            if (sparse) drive(1'b0, ~w[i], 1'b0);
            if (i == 7) begin
                if (push) sb.push_back({ones, w});
                if (rdy_last) word_ready = 1'b1;
            end
            drive(1'b1, w[i], 1'b0);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_word"}, word_out, 0);
        chk({tag, "_valid"}, word_valid, 0);
        chk({tag, "_ones"}, ones_out, 0);
        chk({tag, "_cnt"}, word_cnt, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_valid4"}, word_valid4, 0);
        chk({tag, "_cnt4"}, word_cnt4, 0);
        chk({tag, "_ovf4"}, overflow4, 0);
    endtask

    task automatic chk_word(input string tag, input logic [7:0] w, input logic [3:0] ones);
        chk({tag, "_valid"}, word_valid, 1);
        chk({tag, "_word"}, word_out, w);
        chk({tag, "_ones"}, ones_out, ones);
    endtask

    initial begin
        logic [7:0] rw;
        tbl[0] = '{8'h8D, 1'b0, 4'd4};
        tbl[1] = '{8'h8D, 1'b1, 4'd4};
        tbl[2] = '{8'hA5, 1'b0, 4'd4};
        tbl[3] = '{8'h3C, 1'b0, 4'd4};
        tbl[4] = '{8'h00, 1'b1, 4'd0};
        tbl[5] = '{8'hFF, 1'b0, 4'd8};
        tbl[6] = '{8'h01, 1'b0, 4'd1};
        tbl[7] = '{8'h80, 1'b1, 4'd1};
        rst = 1'b1;
        y_in = 1'b0;
        y_valid = 1'b0;
        flush = 1'b0;
        word_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_zero("reset");

        send_word(8'h8D, 1'b0, 1'b1, 4'd4, 1'b0);
        chk_word("t1", 8'h8D, 4'd4);
        drive(1'b0, 1'b1, 1'b0);
        chk("t1_valid_drop", word_valid, 0);
        chk("t1_cnt", word_cnt, 1);

        for (int k = 0; k < 8; k++) begin
            send_word(tbl[k].w, tbl[k].sparse, 1'b1, tbl[k].ones, 1'b0);
            chk_word("tbl", tbl[k].w, tbl[k].ones);
        end
        drive(1'b0, 1'b0, 1'b0);

        word_ready = 1'b0;
        send_word(8'hA5, 1'b0, 1'b1, 4'd4, 1'b0);
        chk_word("t4_first", 8'hA5, 4'd4);
        send_word(8'h3C, 1'b0, 1'b1, 4'd4, 1'b1);
        chk_word("t4_nobubble", 8'h3C, 4'd4);
        drive(1'b0, 1'b0, 1'b0);
        chk("t4_valid_drop", word_valid, 0);
        chk("t4_cnt", word_cnt, exp_cnt);
        chk("t4_ovf", overflow, 0);

        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        send_word(8'h0F, 1'b0, 1'b1, 4'd4, 1'b0);
        chk_word("t5", 8'h0F, 4'd4);
        chk("t5_ovf", overflow, 0);
        drive(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        chk("flush_done_valid", word_valid, 0);
        chk("flush_done_ovf", overflow, 0);
        send_word(8'h81, 1'b0, 1'b1, 4'd2, 1'b0);
        chk_word("post_flush", 8'h81, 4'd2);

        for (int k = 0; k < 6; k++) begin
            rw = 8'($urandom);
            send_word(rw, 1'b0, 1'b1, 4'($countones(rw)), 1'b0);
            chk_word("rand", rw, 4'($countones(rw)));
        end
        drive(1'b0, 1'b0, 1'b0);
        chk("cnt16", word_cnt, exp_cnt);
        chk("cnt4_wrap", word_cnt4, exp_cnt % 16);

        word_ready = 1'b0;
        send_word(8'hFF, 1'b0, 1'b1, 4'd8, 1'b0);
        send_word(8'h00, 1'b0, 1'b0, 4'd0, 1'b0);
        chk_word("t3_held", 8'hFF, 4'd8);
        chk("t3_ovf", overflow, 1);
        chk("t3_ovf4", overflow4, 1);
        word_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        chk("t3_valid_drop", word_valid, 0);
        chk("t3_cnt", word_cnt, exp_cnt);
        chk("t3_ovf_sticky", overflow, 1);

        word_ready = 1'b0;
        send_word(8'h33, 1'b0, 1'b1, 4'd4, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        sb.delete();
        exp_cnt = 0;
        drive(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        chk_zero("rst_mid");
        word_ready = 1'b1;
        send_word(8'h5A, 1'b0, 1'b1, 4'd4, 1'b0);
        chk_word("rst_clean", 8'h5A, 4'd4);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("rst_cnt", word_cnt, 1);
        chk("rst_ovf", overflow, 0);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
